dm_load_ext: RTL and testbench
==============================

// Module: dm_load_ext
// PURPOSE
//  Load-data extension unit of the MEM stage in the 5-stage MIPS pipeline.
//  Takes the raw 32-bit word read from data memory and, using the opcode of the
//  instruction in MEM (IR_M) and the low address bits, selects the addressed
//  byte or halfword and sign- or zero-extends it. The result is registered and
//  feeds the MEM/WB path. Also flags misaligned loads.
// PARAMETERS
//  none (opcodes are fixed constants from the shared package)
// PORTS
//  clk               input   1   single clock, rising edge
//  reset             input   1   asynchronous, active-low reset (0 = reset)
//  IR_M              input   32  instruction currently in MEM; opcode = IR_M[31:26]
//  DM_RD_in          input   32  raw word read from data memory (word-aligned)
//  MemAddr           input   32  byte address of the access; only [1:0] used
//  DM_RD_out         output  32  extended load data, registered
//  load_misaligned   output  1   registered misaligned-load flag
// BEHAVIOUR
//  - Reset (reset=0, async): DM_RD_out=32'h0, load_misaligned=0; held while low.
//  - Latency: 1 cycle. Inputs sampled at a rising clk edge appear on outputs
//    after that edge; outputs otherwise hold. No handshake, no enable.
//  - Byte order little-endian: byte k = DM_RD_in[8k+7:8k], k = MemAddr[1:0];
//    halfword h = DM_RD_in[16h+15:16h], h = MemAddr[1].
//  - Opcode decode (IR_M[31:26]):
//    100011 lw  : out = DM_RD_in
//    100000 lb  : out = sign-extend byte k to 32 bits
//    100100 lbu : out = zero-extend byte k
//    100001 lh  : out = sign-extend halfword h
//    100101 lhu : out = zero-extend halfword h
//    any other  : out = DM_RD_in unchanged, load_misaligned = 0
//  - Misalignment: lw with MemAddr[1:0]!=0, or lh/lhu with MemAddr[0]=1 ->
//    load_misaligned=1. Data is still produced per the rules above (lw passes
//    word; lh/lhu use MemAddr[1] only). lb/lbu never misaligned.
//  - MemAddr[31:2] and IR_M[25:0] are ignored.
//  - Reset asserted mid-operation clears outputs immediately; first valid
//    output is one edge after reset deasserts.
// STRUCTURE
//  - Shared package: opcode constants (OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU),
//    load-kind enum {LD_NONE, LD_W, LD_B, LD_BU, LD_H, LD_HU}.
//  - One combinational sub-module dm_load_sel: (kind, DM_RD_in, addr[1:0]) ->
//    (ext_data, misaligned). Top decodes opcode to kind and holds the output
//    register with async active-low reset.
// TESTING
//  - Reset: reset=0 with DM_RD_in=32'hFFFFFFFF, lb -> DM_RD_out=0, flag=0;
//    release, next edge -> 32'hFFFFFFFF.
//  - lb/lbu: DM_RD_in=32'h8180_7F01, addr 0..3: lb -> 00000001,0000007F,
//    FFFFFF80,FFFFFF81; lbu -> 01,7F,80,81 zero-extended; flag 0.
//  - lh/lhu: DM_RD_in=32'h8001_7FFF: addr 0 lh -> 00007FFF; addr 2 lh ->
//    FFFF8001, lhu -> 00008001; addr 1 lh -> flag 1, data 00007FFF.
//  - lw: DM_RD_in=32'hDEADBEEF addr 0 -> DEADBEEF flag 0; addr 2 -> DEADBEEF
//    flag 1.
//  - Non-load (IR_M opcode 000000, sw 101011): DM_RD_in=12345678, addr 3 ->
//    12345678, flag 0.
//  - Latency: change inputs between edges -> outputs change only at next
//    rising edge; async reset pulse mid-cycle clears outputs without clk.

Source files
------------

// File: rtl/dm_load_ext_pkg.sv
// rtl/dm_load_ext_pkg.sv - shared load opcodes and load-kind type for the MEM stage
//
// Purpose : MIPS load opcode constants, the load-kind enum used between the
//           opcode decoder and the byte/halfword selector, and the decoder
//           function itself.
// Contents: OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, load_kind_e, decode_load_kind()

package dm_load_ext_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_W    = 3'd1,
    LD_B    = 3'd2,
    LD_BU   = 3'd3,
    LD_H    = 3'd4,
    LD_HU   = 3'd5
  } load_kind_e;

  // Anything that is not one of the five loads passes the memory word through.
  function automatic load_kind_e decode_load_kind(input logic [5:0] opcode);
    load_kind_e kind;
    case (opcode)
      OP_LW:   kind = LD_W;
      OP_LB:   kind = LD_B;
      OP_LBU:  kind = LD_BU;
      OP_LH:   kind = LD_H;
      OP_LHU:  kind = LD_HU;
      default: kind = LD_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/dm_load_sel.sv
// rtl/dm_load_sel.sv - combinational byte/halfword select and extend for loads
//
// Purpose : Picks the addressed byte or halfword out of a little-endian memory
//           word, sign- or zero-extends it, and flags misaligned word/halfword
//           accesses.
// Ports   : i_kind        load kind decoded from the opcode
//           i_rd_data     raw 32-bit word from data memory
//           i_addr        low two byte-address bits
//           o_ext_data    extended load data
//           o_misaligned  1 for lw with addr!=0 or lh/lhu with addr[0]=1

module dm_load_sel
  import dm_load_ext_pkg::*;
(
  input  load_kind_e  i_kind,
  input  logic [31:0] i_rd_data,
  input  logic [1:0]  i_addr,
  output logic [31:0] o_ext_data,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian: byte k lives at bits [8k+7:8k]; halfword chosen by addr[1]
  // alone, so a misaligned halfword still returns the enclosing aligned half.
  assign w_byte = i_rd_data[{i_addr, 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_rd_data[31:16] : i_rd_data[15:0];

  always_comb begin
    o_ext_data   = i_rd_data;
    o_misaligned = 1'b0;
    case (i_kind)
      LD_W: begin
        o_ext_data   = i_rd_data;
        o_misaligned = |i_addr;
      end
      LD_B:  o_ext_data = {{24{w_byte[7]}}, w_byte};
      LD_BU: o_ext_data = {24'h000000, w_byte};
      LD_H: begin
        o_ext_data   = {{16{w_half[15]}}, w_half};
        o_misaligned = i_addr[0];
      end
      LD_HU: begin
        o_ext_data   = {16'h0000, w_half};
        o_misaligned = i_addr[0];
      end
      default: begin
        o_ext_data   = i_rd_data;
        o_misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dm_load_ext.sv
// rtl/dm_load_ext.sv - registered load-data extension unit for the MEM stage
//
// Purpose : Decodes the MEM-stage opcode into a load kind, extends the raw
//           memory word accordingly and registers the result (1-cycle
//           latency) together with a misaligned-load flag.
// Ports   : clk              rising-edge clock
//           reset            asynchronous active-low reset
//           IR_M             instruction in MEM, opcode in [31:26]
//           DM_RD_in         raw word read from data memory
//           MemAddr          byte address of the access, only [1:0] used
//           DM_RD_out        registered extended load data
//           load_misaligned  registered misaligned-load flag

module dm_load_ext
  import dm_load_ext_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_M,
  input  logic [31:0] DM_RD_in,
  input  logic [31:0] MemAddr,
  output logic [31:0] DM_RD_out,
  output logic        load_misaligned
);

  load_kind_e  w_kind;
  logic [31:0] w_ext_data;
  logic        w_misaligned;
  logic [31:0] r_data;
  logic        r_misaligned;

  // Instruction operand fields and upper address bits play no part here.
  logic        w_unused_bits;
  assign w_unused_bits = ^{IR_M[25:0], MemAddr[31:2]};

  assign w_kind = decode_load_kind(IR_M[31:26]);

  dm_load_sel u_sel (
    .i_kind       (w_kind),
    .i_rd_data    (DM_RD_in),
    .i_addr       (MemAddr[1:0]),
    .o_ext_data   (w_ext_data),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data       <= 32'h0000_0000;
      r_misaligned <= 1'b0;
    end else begin
      r_data       <= w_ext_data;
      r_misaligned <= w_misaligned;
    end
  end

  assign DM_RD_out       = r_data;
  assign load_misaligned = r_misaligned;

endmodule

// File: tb/tb_dm_load_ext.sv
// tb/tb_dm_load_ext.sv - directed self-checking bench for dm_load_ext

module tb_dm_load_ext;

  localparam logic [5:0] T_LW  = 6'b100011;
  localparam logic [5:0] T_LB  = 6'b100000;
  localparam logic [5:0] T_LBU = 6'b100100;
  localparam logic [5:0] T_LH  = 6'b100001;
  localparam logic [5:0] T_LHU = 6'b100101;
  localparam logic [5:0] T_RT  = 6'b000000;
  localparam logic [5:0] T_SW  = 6'b101011;

  logic        clk;
  logic        reset;
  logic [31:0] IR_M;
  logic [31:0] DM_RD_in;
  logic [31:0] MemAddr;
  logic [31:0] DM_RD_out;
  logic        load_misaligned;

  int tests_run;
  int tests_failed;

  dm_load_ext dut (
    .clk             (clk),
    .reset           (reset),
    .IR_M            (IR_M),
    .DM_RD_in        (DM_RD_in),
    .MemAddr         (MemAddr),
    .DM_RD_out       (DM_RD_out),
    .load_misaligned (load_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Set inputs (with junk in the ignored fields) without waiting for a clock.
  task automatic set_in(input logic [5:0] op, input logic [1:0] a, input logic [31:0] d);
    IR_M     = {op, 26'h2A5_A5A5};
    MemAddr  = {30'h2BAD_CAFE, a};
    DM_RD_in = d;
  endtask

  // Apply on the falling edge, sample 1 time unit after the next rising edge.
  task automatic apply(input logic [5:0] op, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    set_in(op, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] exp_d, input logic exp_f);
    check({tag, ".data"}, DM_RD_out, exp_d);
    check({tag, ".flag"}, {31'd0, load_misaligned}, {31'd0, exp_f});
  endtask

  logic [31:0] lb_exp  [4];
  logic [31:0] lbu_exp [4];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    lb_exp  = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FF80, 32'hFFFF_FF81};
    lbu_exp = '{32'h0000_0001, 32'h0000_007F, 32'h0000_0080, 32'h0000_0081};

    // Reset held: outputs stay clear across clock edges.
    reset = 1'b0;
    set_in(T_LB, 2'd0, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    expect_out("reset_hold", 32'h0, 1'b0);

    // Release; first edge after release captures the load.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    expect_out("reset_release", 32'hFFFF_FFFF, 1'b0);

    for (int k = 0; k < 4; k++) begin
      apply(T_LB, k[1:0], 32'h8180_7F01);
      expect_out($sformatf("lb_a%0d", k), lb_exp[k], 1'b0);
      apply(T_LBU, k[1:0], 32'h8180_7F01);
      expect_out($sformatf("lbu_a%0d", k), lbu_exp[k], 1'b0);
    end

    apply(T_LH, 2'd0, 32'h8001_7FFF);  expect_out("lh_a0",  32'h0000_7FFF, 1'b0);
    apply(T_LH, 2'd2, 32'h8001_7FFF);  expect_out("lh_a2",  32'hFFFF_8001, 1'b0);
    apply(T_LHU, 2'd2, 32'h8001_7FFF); expect_out("lhu_a2", 32'h0000_8001, 1'b0);
    apply(T_LHU, 2'd0, 32'h8001_7FFF); expect_out("lhu_a0", 32'h0000_7FFF, 1'b0);
    apply(T_LH, 2'd1, 32'h8001_7FFF);  expect_out("lh_a1",  32'h0000_7FFF, 1'b1);
    apply(T_LH, 2'd3, 32'h8001_7FFF);  expect_out("lh_a3",  32'hFFFF_8001, 1'b1);
    apply(T_LHU, 2'd3, 32'h8001_7FFF); expect_out("lhu_a3", 32'h0000_8001, 1'b1);

    apply(T_LW, 2'd0, 32'hDEAD_BEEF);  expect_out("lw_a0", 32'hDEAD_BEEF, 1'b0);
    apply(T_LW, 2'd2, 32'hDEAD_BEEF);  expect_out("lw_a2", 32'hDEAD_BEEF, 1'b1);
    apply(T_LW, 2'd1, 32'hDEAD_BEEF);  expect_out("lw_a1", 32'hDEAD_BEEF, 1'b1);

    apply(T_RT, 2'd3, 32'h1234_5678);  expect_out("rtype_a3", 32'h1234_5678, 1'b0);
    apply(T_SW, 2'd3, 32'h1234_5678);  expect_out("sw_a3",    32'h1234_5678, 1'b0);
    apply(T_LB, 2'd3, 32'h1234_5678);  expect_out("lb_pos_a3", 32'h0000_0012, 1'b0);

    // Latency: new inputs between edges must not show until the next rising edge.
    apply(T_LW, 2'd3, 32'hCAFE_F00D);  expect_out("lat_setup", 32'hCAFE_F00D, 1'b1);
    @(negedge clk);
    set_in(T_LBU, 2'd0, 32'h0000_00A5);
    #2;
    expect_out("lat_hold", 32'hCAFE_F00D, 1'b1);
    @(posedge clk); #1;
    expect_out("lat_update", 32'h0000_00A5, 1'b0);

    // Async reset pulse in the middle of the high phase clears without a clock edge.
    apply(T_LH, 2'd1, 32'h9999_8888);  expect_out("areset_setup", 32'hFFFF_8888, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    expect_out("areset_clear", 32'h0, 1'b0);
    reset = 1'b1;
    #1;
    expect_out("areset_hold", 32'h0, 1'b0);
    @(posedge clk); #1;
    expect_out("areset_resume", 32'hFFFF_8888, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
